// File: rtl/uart_tx_scheduler_if.sv
// Register-port bus between the TX scheduler and a W65C51N-style UART.
// The scheduler is the master; the UART drives read data back one cycle after a read.
interface uart_tx_scheduler_if;
    logic       uart_cs;
    logic       uart_rw;
    logic       uart_rs0;
    logic       uart_rs1;
    logic [7:0] uart_wdata;
    logic [7:0] uart_rdata;

    modport master (
        output uart_cs,
        output uart_rw,
        output uart_rs0,
        output uart_rs1,
        output uart_wdata,
        input  uart_rdata
    );

    modport slave (
        input  uart_cs,
        input  uart_rw,
        input  uart_rs0,
        input  uart_rs1,
        input  uart_wdata,
        output uart_rdata
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART register-port master: init writes, status polling, round-robin TX arbitration.
// Define UART_SCHED_RX_EN to add the RX drain path to a valid/ready sink.
//
//  state       | meaning
//  ------------+--------------------------------------------------------
//  S_INIT_CMD  | write command register (rs=10) with CMD_INIT
//  S_INIT_CTRL | write control register (rs=11) with CTRL_INIT
//  S_GAP       | idle POLL_GAP cycles between polls
//  S_STAT_RD   | read status register (rs=01)
//  S_STAT_EV   | evaluate status byte returned by the UART
//  S_TX_WR     | write the arbitration winner's byte to TX data (rs=00)
//  S_RX_RD     | read RX data register (rs=00), RX build only
//  S_RX_EV     | capture received byte into rx_data, RX build only
module uart_tx_scheduler #(
    parameter int         NUM_REQ   = 2,
    parameter logic [7:0] CMD_INIT  = 8'h0B,
    parameter logic [7:0] CTRL_INIT = 8'h1E,
    parameter int         POLL_GAP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [2:0]             grant_idx,
    output logic                   busy,
    uart_tx_scheduler_if.master    bus,
    output logic                   rx_valid,
    output logic [7:0]             rx_data,
    input  logic                   rx_ready
);

    localparam int GW = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_INIT_CMD  = 3'd0,
        S_INIT_CTRL = 3'd1,
        S_GAP       = 3'd2,
        S_STAT_RD   = 3'd3,
        S_STAT_EV   = 3'd4,
        S_TX_WR     = 3'd5
`ifdef UART_SCHED_RX_EN
        ,
        S_RX_RD     = 3'd6,
        S_RX_EV     = 3'd7
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;
    logic [2:0]      grant_nxt;
    logic            enter_gap;
    logic            rx_load;

    logic            cs_c, rw_c;
    logic [1:0]      rs_c;
    logic [7:0]      wdata_c;
    logic [NUM_REQ-1:0] ready_c;

    logic            win_found;
    logic [7:0]      win_data;
    int              arb_start, arb_best, arb_win, arb_d;

    logic            tdre, rdrf;
    assign tdre = bus.uart_rdata[4];
    assign rdrf = bus.uart_rdata[3];

    // Round-robin: the requester closest after the last grant (with wrap) wins.
    always_comb begin
        arb_start = int'(grant_idx) + 1;
        if (arb_start >= NUM_REQ) arb_start = 0;
        arb_best  = NUM_REQ;
        arb_win   = 0;
        arb_d     = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j]) begin
                arb_d = j - arb_start;
                if (arb_d < 0) arb_d = arb_d + NUM_REQ;
                if (arb_d < arb_best) begin
                    arb_best = arb_d;
                    arb_win  = j;
                end
            end
        end
        win_found = (arb_best < NUM_REQ);
        win_data  = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j == arb_win) win_data = req_data[8*j +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        grant_nxt = grant_idx;
        enter_gap = 1'b0;
        rx_load   = 1'b0;
        cs_c      = 1'b0;
        rw_c      = 1'b1;
        rs_c      = 2'b00;
        wdata_c   = 8'h00;
        ready_c   = '0;

        case (state)
            S_INIT_CMD: begin
                cs_c      = 1'b1;
                rw_c      = 1'b0;
                rs_c      = 2'b10;
                wdata_c   = CMD_INIT;
                state_nxt = S_INIT_CTRL;
            end
            S_INIT_CTRL: begin
                cs_c      = 1'b1;
                rw_c      = 1'b0;
                rs_c      = 2'b11;
                wdata_c   = CTRL_INIT;
                enter_gap = 1'b1;
            end
            S_GAP: begin
                if (gap_cnt == '0) state_nxt = S_STAT_RD;
                else               gap_nxt   = gap_cnt - GW'(1);
            end
            S_STAT_RD: begin
                cs_c      = 1'b1;
                rw_c      = 1'b1;
                rs_c      = 2'b01;
                state_nxt = S_STAT_EV;
            end
            S_STAT_EV: begin
`ifdef UART_SCHED_RX_EN
                if (rdrf && !rx_valid)            state_nxt = S_RX_RD;
                else if (tdre && (|req_valid))    state_nxt = S_TX_WR;
                else                              enter_gap = 1'b1;
`else
                if (tdre && (|req_valid))         state_nxt = S_TX_WR;
                else                              enter_gap = 1'b1;
`endif
            end
            S_TX_WR: begin
                // A requester that withdrew since the poll simply gets no write.
                if (win_found) begin
                    cs_c      = 1'b1;
                    rw_c      = 1'b0;
                    rs_c      = 2'b00;
                    wdata_c   = win_data;
                    grant_nxt = 3'(arb_win);
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (j == arb_win) ready_c[j] = 1'b1;
                    end
                end
                enter_gap = 1'b1;
            end
`ifdef UART_SCHED_RX_EN
            S_RX_RD: begin
                cs_c      = 1'b1;
                rw_c      = 1'b1;
                rs_c      = 2'b00;
                state_nxt = S_RX_EV;
            end
            S_RX_EV: begin
                rx_load   = 1'b1;
                enter_gap = 1'b1;
            end
`endif
            default: state_nxt = S_INIT_CMD;
        endcase

        if (enter_gap) begin
            if (POLL_GAP == 0) begin
                state_nxt = S_STAT_RD;
            end else begin
                state_nxt = S_GAP;
                gap_nxt   = GAP_LOAD;
            end
        end

        // Reset kills any access in the cycle it is asserted.
        if (rst) begin
            cs_c    = 1'b0;
            rw_c    = 1'b1;
            rs_c    = 2'b00;
            wdata_c = 8'h00;
            ready_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT_CMD;
            gap_cnt   <= '0;
            grant_idx <= 3'(NUM_REQ - 1);
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            grant_idx <= grant_nxt;
        end
    end

    assign bus.uart_cs    = cs_c;
    assign bus.uart_rw    = rw_c;
    assign bus.uart_rs0   = rs_c[0];
    assign bus.uart_rs1   = rs_c[1];
    assign bus.uart_wdata = wdata_c;
    assign req_ready      = ready_c;
    assign busy           = rst | (state != S_GAP);

`ifdef UART_SCHED_RX_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else if (rx_load) begin
            rx_valid <= 1'b1;
            rx_data  <= bus.uart_rdata;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end
    logic unused_rx;
    assign unused_rx = rdrf;
`else
    assign rx_valid = 1'b0;
    assign rx_data  = 8'h00;
    logic unused_rx;
    assign unused_rx = ^{rx_ready, rx_load, rdrf, bus.uart_rdata[7:5], bus.uart_rdata[3:0]};
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small UART register model.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [2:0]  grant_idx;
    logic        busy;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;

    logic [7:0]  status;
    logic [7:0]  rx_byte;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int txw_cnt = 0;
    int rxr_cnt = 0;
    int rr0_cnt = 0;
    int rr1_cnt = 0;

    uart_tx_scheduler_if bus();

    uart_tx_scheduler #(
        .NUM_REQ(2), .CMD_INIT(8'h0B), .CTRL_INIT(8'h1E), .POLL_GAP(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .grant_idx(grant_idx), .busy(busy), .bus(bus),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART register model: read data appears the cycle after the read.
    always @(posedge clk) begin
        if (rst) bus.uart_rdata <= 8'h00;
        else if (bus.uart_cs && bus.uart_rw)
            bus.uart_rdata <= ({bus.uart_rs1, bus.uart_rs0} == 2'b01) ? status : rx_byte;
    end

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (bus.uart_cs && !bus.uart_rw && {bus.uart_rs1, bus.uart_rs0} == 2'b00) txw_cnt <= txw_cnt + 1;
        if (bus.uart_cs &&  bus.uart_rw && {bus.uart_rs1, bus.uart_rs0} == 2'b00) rxr_cnt <= rxr_cnt + 1;
        if (req_ready[0]) rr0_cnt <= rr0_cnt + 1;
        if (req_ready[1]) rr1_cnt <= rr1_cnt + 1;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_bus(input logic [1:0] rs, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.uart_cs && {bus.uart_rs1, bus.uart_rs0} == rs) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        logic [11:0] acc;
        rst = 1'b1; req_valid = 2'b00; req_data = 16'h0000;
        status = 8'h00; rx_byte = 8'h00; rx_ready = 1'b0;
        repeat (3) cyc();
        acc = {bus.uart_cs, bus.uart_rw, bus.uart_rs1, bus.uart_rs0, bus.uart_wdata};
        n_cmp++; if (acc !== {1'b0, 1'b1, 2'b00, 8'h00}) begin n_err++; $display("FAIL reset_bus: got %h want %h", acc, {1'b0, 1'b1, 2'b00, 8'h00}); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        n_cmp++; if (grant_idx !== 3'd1) begin n_err++; $display("FAIL reset_grant: got %0d want 1", grant_idx); end
        n_cmp++; if ({rx_valid, rx_data} !== 9'h000) begin n_err++; $display("FAIL reset_rx: got %h want 000", {rx_valid, rx_data}); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        acc = {bus.uart_cs, bus.uart_rw, bus.uart_rs1, bus.uart_rs0, bus.uart_wdata};
        n_cmp++; if (acc !== {1'b1, 1'b0, 2'b10, 8'h0B}) begin n_err++; $display("FAIL init_cmd: got %h want %h", acc, {1'b1, 1'b0, 2'b10, 8'h0B}); end
        cyc();
        acc = {bus.uart_cs, bus.uart_rw, bus.uart_rs1, bus.uart_rs0, bus.uart_wdata};
        n_cmp++; if (acc !== {1'b1, 1'b0, 2'b11, 8'h1E}) begin n_err++; $display("FAIL init_ctrl: got %h want %h", acc, {1'b1, 1'b0, 2'b11, 8'h1E}); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++; if ({bus.uart_cs, busy} !== 2'b00) begin n_err++; $display("FAIL init_gap%0d: cs,busy got %b want 00", i, {bus.uart_cs, busy}); end
        end
        cyc();
        n_cmp++; if ({bus.uart_cs, bus.uart_rw, bus.uart_rs1, bus.uart_rs0} !== 4'b1101) begin
            n_err++; $display("FAIL first_poll: got %b want 1101", {bus.uart_cs, bus.uart_rw, bus.uart_rs1, bus.uart_rs0}); end
    endtask

    task automatic test_no_tdre();
        bit ok;
        int tprev, tx0, r0;
        status = 8'h00; req_valid = 2'b01; req_data = 16'h0041;
        tx0 = txw_cnt; r0 = rr0_cnt; tprev = 0;
        cyc();
        for (int p = 0; p < 10; p++) begin
            wait_bus(2'b01, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL no_tdre_poll%0d: got timeout want status read", p); end
            if (p > 0) begin
                n_cmp++; if (cyc_cnt - tprev != 6) begin n_err++; $display("FAIL no_tdre_period%0d: got %0d want 6", p, cyc_cnt - tprev); end
            end
            tprev = cyc_cnt;
            cyc();
        end
        n_cmp++; if (txw_cnt != tx0) begin n_err++; $display("FAIL no_tdre_writes: got %0d want 0", txw_cnt - tx0); end
        n_cmp++; if (rr0_cnt != r0) begin n_err++; $display("FAIL no_tdre_ready: got %0d want 0", rr0_cnt - r0); end
    endtask

    task automatic test_single();
        bit ok;
        int tx0, r0, r1;
        status = 8'h10; req_valid = 2'b01; req_data = 16'h0041;
        tx0 = txw_cnt; r0 = rr0_cnt; r1 = rr1_cnt;
        wait_bus(2'b00, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_write: got timeout want write"); end
        n_cmp++; if ({bus.uart_rw, bus.uart_wdata} !== 9'h041) begin n_err++; $display("FAIL single_wdata: got %h want 041", {bus.uart_rw, bus.uart_wdata}); end
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b want 01", req_ready); end
        cyc();
        req_valid = 2'b00;
        n_cmp++; if (grant_idx !== 3'd0) begin n_err++; $display("FAIL single_grant: got %0d want 0", grant_idx); end
        repeat (20) cyc();
        n_cmp++; if (txw_cnt - tx0 != 1) begin n_err++; $display("FAIL single_nwrites: got %0d want 1", txw_cnt - tx0); end
        n_cmp++; if ({rr0_cnt - r0, rr1_cnt - r1} !== {32'd1, 32'd0}) begin n_err++; $display("FAIL single_pulses: got %0d,%0d want 1,0", rr0_cnt - r0, rr1_cnt - r1); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int tprev;
        logic [7:0] exp_d;
        req_valid = 2'b11; req_data = {8'hAA, 8'h55}; status = 8'h10;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        tprev = 0;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0) ? 8'h55 : 8'hAA;
            wait_bus(2'b00, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_write%0d: got timeout want write", k); end
            n_cmp++; if ({bus.uart_rw, bus.uart_wdata} !== {1'b0, exp_d}) begin n_err++; $display("FAIL b2b_wdata%0d: got %h want %h", k, {bus.uart_rw, bus.uart_wdata}, {1'b0, exp_d}); end
            n_cmp++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL b2b_ready%0d: got %b", k, req_ready); end
            if (k > 0) begin
                n_cmp++; if (cyc_cnt - tprev != 7) begin n_err++; $display("FAIL b2b_spacing%0d: got %0d want 7", k, cyc_cnt - tprev); end
            end
            tprev = cyc_cnt;
            cyc();
            n_cmp++; if (grant_idx !== 3'(k % 2)) begin n_err++; $display("FAIL b2b_grant%0d: got %0d want %0d", k, grant_idx, k % 2); end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_rx();
        bit ok;
        int rx0;
`ifdef UART_SCHED_RX_EN
        rx_byte = 8'h5A; rx_ready = 1'b0; status = 8'h18;
        req_valid = 2'b01; req_data = 16'h0041;
        wait_bus(2'b00, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rx_read: got timeout want rx read"); end
        n_cmp++; if (bus.uart_rw !== 1'b1) begin n_err++; $display("FAIL rx_first: got rw=%b want 1", bus.uart_rw); end
        cyc();
        cyc();
        n_cmp++; if ({rx_valid, rx_data} !== 9'h15A) begin n_err++; $display("FAIL rx_capture: got %h want 15a", {rx_valid, rx_data}); end
        wait_bus(2'b00, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rx_tx_write: got timeout want write"); end
        n_cmp++; if ({bus.uart_rw, bus.uart_wdata} !== 9'h041) begin n_err++; $display("FAIL rx_tx_wdata: got %h want 041", {bus.uart_rw, bus.uart_wdata}); end
        n_cmp++; if ({rx_valid, rx_data} !== 9'h15A) begin n_err++; $display("FAIL rx_hold: got %h want 15a", {rx_valid, rx_data}); end
        cyc();
        req_valid = 2'b00; rx_ready = 1'b1; status = 8'h00;
        cyc();
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rx_drain: got %b want 0", rx_valid); end
        rx_ready = 1'b0;
        rx0 = rxr_cnt;
        repeat (12) cyc();
        n_cmp++; if (rxr_cnt != rx0) begin n_err++; $display("FAIL rx_idle_reads: got %0d want 0", rxr_cnt - rx0); end
`else
        rx_byte = 8'h5A; rx_ready = 1'b0; status = 8'h18;
        req_valid = 2'b01; req_data = 16'h0041;
        rx0 = rxr_cnt;
        wait_bus(2'b00, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL norx_write: got timeout want write"); end
        n_cmp++; if ({bus.uart_rw, bus.uart_wdata} !== 9'h041) begin n_err++; $display("FAIL norx_wdata: got %h want 041", {bus.uart_rw, bus.uart_wdata}); end
        cyc();
        req_valid = 2'b00;
        repeat (12) cyc();
        n_cmp++; if (rxr_cnt != rx0) begin n_err++; $display("FAIL norx_reads: got %0d want 0", rxr_cnt - rx0); end
        n_cmp++; if ({rx_valid, rx_data} !== 9'h000) begin n_err++; $display("FAIL norx_rx: got %h want 000", {rx_valid, rx_data}); end
        status = 8'h00;
`endif
    endtask

    task automatic test_reset_abort();
        bit ok;
        int tx0, r0;
        logic [11:0] acc;
        status = 8'h10; req_valid = 2'b01; req_data = 16'h0041;
        wait_bus(2'b01, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL abort_poll: got timeout want status read"); end
        cyc();
        tx0 = txw_cnt; r0 = rr0_cnt;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.uart_cs !== 1'b0) begin n_err++; $display("FAIL abort_cs_now: got %b want 0", bus.uart_cs); end
        cyc();
        cyc();
        n_cmp++; if ({bus.uart_cs, req_ready, busy} !== 4'b0001) begin n_err++; $display("FAIL abort_held: got %b want 0001", {bus.uart_cs, req_ready, busy}); end
        n_cmp++; if (grant_idx !== 3'd1) begin n_err++; $display("FAIL abort_grant: got %0d want 1", grant_idx); end
        rst = 1'b0;
        #1;
        acc = {bus.uart_cs, bus.uart_rw, bus.uart_rs1, bus.uart_rs0, bus.uart_wdata};
        n_cmp++; if (acc !== {1'b1, 1'b0, 2'b10, 8'h0B}) begin n_err++; $display("FAIL abort_init_cmd: got %h want %h", acc, {1'b1, 1'b0, 2'b10, 8'h0B}); end
        n_cmp++; if ({txw_cnt - tx0, rr0_cnt - r0} !== {32'd0, 32'd0}) begin n_err++; $display("FAIL abort_no_write: got %0d,%0d want 0,0", txw_cnt - tx0, rr0_cnt - r0); end
        cyc();
        acc = {bus.uart_cs, bus.uart_rw, bus.uart_rs1, bus.uart_rs0, bus.uart_wdata};
        n_cmp++; if (acc !== {1'b1, 1'b0, 2'b11, 8'h1E}) begin n_err++; $display("FAIL abort_init_ctrl: got %h want %h", acc, {1'b1, 1'b0, 2'b11, 8'h1E}); end
        req_valid = 2'b00;
        repeat (4) cyc();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req_data = 16'h0000;
        rx_ready = 1'b0;
        status = 8'h00;
        rx_byte = 8'h00;
        test_reset();
        test_no_tdre();
        test_single();
        test_back_to_back();
        test_rx();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
